shift_pipe: RTL and testbench
=============================

# shift_pipe

Parametrised, pipelined shift/rotate unit for the execute stage. It generalises the single-cycle 32-bit SLL/SRL/SRA shifter in three ways: configurable width (XLEN), ROL/ROR modes, and a registered pipeline with valid/ready backpressure. A pass-through tag lets the issuing stage match results to their destination register.

## Interface
- XLEN, 32: operand and result width; power of two, 8..64.
- SHW, $clog2(XLEN): derived shift-amount width; not overridable.
- PIPE_STAGES, 2: register stages, 1..SHW; equals the latency in cycles.
- TAG_W, 5: width of the pass-through tag.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of every in-flight operation.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- operand_a  in  XLEN  value to shift.
- operand_b  in  XLEN  shift amount; only [SHW-1:0] is used.
- sel  in  3  000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR; all other codes behave as SLL.
- in_tag  in  TAG_W  carried unchanged to out_tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- shift_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.

## Operation
- shamt = operand_b[SHW-1:0]. Upper bits of operand_b are ignored (RV semantics).
- SLL: a << shamt, zero fill.
- SRL: a >> shamt, zero fill.
- SRA: a >> shamt, filled with a[XLEN-1].
- ROL: (a << shamt) | (a >> (XLEN-shamt)); shamt = 0 returns a unchanged.
- ROR: mirror of ROL.
- The shift is built as SHW log levels. Level k shifts by 2^k and sits in register stage floor(k*PIPE_STAGES/SHW).
- Each stage register holds a valid bit, the partial result, and the remaining control (shamt bits, sel, fill bit, tag).
- The final stage registers drive the outputs directly. No combinational path runs from operand_a to shift_result.
- Pipeline enable: adv = !out_valid || out_ready.
  - When adv=1, all stages shift forward together.
  - When adv=0, all stages hold.
- in_ready = adv, purely combinational from out_valid and out_ready. There is no bubble collapsing: the pipeline stalls as a whole.
- Accepting a request loads stage 0 with valid=1. When adv=1 and in_valid=0, stage 0 loads valid=0.
- Once asserted, out_valid, shift_result and out_tag stay stable until the handshake completes.
- flush=1 clears every stage valid bit at the next edge and overrides any acceptance that cycle.
  - in_ready is still adv during flush, but a request presented that cycle is discarded.
  - Data registers may keep stale values. out_valid=0 from the next cycle.

## Timing
- Reset (async assert, sync release recommended upstream) sets all valid bits = 0, shift_result = 0 and out_tag = 0. in_ready therefore reads 1 directly after reset.
- Latency: a request accepted at edge N appears with out_valid=1 after edge N+PIPE_STAGES-1. Its result is visible in the cycle following edge N+PIPE_STAGES-1, i.e. PIPE_STAGES cycles after presentation.
- Throughput: one operation per cycle while out_ready=1.
- Back-to-back with out_ready held at 1: the result stream has no bubbles and stays in order.
- out_ready low while out_valid=1:
  - in_ready drops in the same cycle.
  - No new acceptance occurs; in-flight data is not lost or duplicated.
- out_ready rising again: the held result is consumed on that edge and the pipeline advances on the same edge.
- Reset asserted mid-operation: all in-flight data is dropped immediately. Outputs go to their reset values asynchronously.
- flush together with out_ready=1 and out_valid=1: the displayed result counts as consumed, and out_valid=0 next cycle.

## Test plan
- XLEN=32, PIPE_STAGES=2, out_ready=1:
  - SRA a=0x8000_0010, b=4 -> 0xF800_0001 with tag preserved, two cycles after acceptance.
  - SRL of the same operands -> 0x0800_0001.
- Rotates at XLEN=32:
  - ROL a=0x8000_0001, b=1 -> 0x0000_0003.
  - ROR a=0x0000_0001, b=0x21 (upper bits ignored) -> 0x8000_0000.
  - ROL with shamt 0 -> a unchanged.
- Backpressure: stream tags 1..6, one per cycle; hold out_ready=0 for 3 cycles mid-stream -> in_ready tracks adv, all six results arrive in order exactly once, and shift_result stays stable while held.
- Flush: flush while 2 operations are in flight -> out_valid=0 the next cycle and neither result ever appears; the next request completes normally.
- Reset mid-stream: assert rst between edges -> out_valid, shift_result and out_tag all 0 immediately; after release in_ready=1 and SLL a=1, b=31 -> 0x8000_0000.
- Parameter sweep: XLEN=64 with PIPE_STAGES in {1,3,6} against a golden model for random operands and all sel codes; latency must equal PIPE_STAGES, and SRA of 0x8000…0 by 63 -> all ones.

Source files
------------

// File: rtl/shift_pipe.sv
// Pipelined shift/rotate unit: SLL/SRL/SRA/ROL/ROR built from log2(XLEN) shift levels
// spread over PIPE_STAGES registers, stalling as a whole under output backpressure.
module shift_pipe #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   operand_a,
  input  logic [XLEN-1:0]   operand_b,
  input  logic [2:0]        sel,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   shift_result,
  output logic [TAG_W-1:0]  out_tag
);
  localparam int SHW = $clog2(XLEN);

  // Control that travels with each partial result; fill is the SRA sign bit, else 0.
  typedef struct packed {
    logic             right;
    logic             rot;
    logic             fill;
    logic [SHW-1:0]   shamt;
    logic [TAG_W-1:0] tag;
  } ctl_t;

  logic [PIPE_STAGES-1:0] valid_q, valid_d;
  logic [XLEN-1:0]        data_q  [PIPE_STAGES];
  logic [XLEN-1:0]        data_d  [PIPE_STAGES];
  logic [XLEN-1:0]        data_in [PIPE_STAGES];
  ctl_t                   ctl_q   [PIPE_STAGES];
  ctl_t                   ctl_in  [PIPE_STAGES];
  ctl_t                   req_ctl;
  logic                   adv;
  logic                   unused_b;

  function automatic logic [XLEN-1:0] level_shift(input logic [XLEN-1:0] x,
                                                  input int amt,
                                                  input logic right,
                                                  input logic rot,
                                                  input logic fill);
    logic [XLEN-1:0] fill_mask;
    fill_mask = ~({XLEN{1'b1}} >> amt);
    if (!right)
      return rot ? ((x << amt) | (x >> (XLEN - amt))) : (x << amt);
    else if (rot)
      return (x >> amt) | (x << (XLEN - amt));
    else
      return (x >> amt) | (fill ? fill_mask : '0);
  endfunction

  // Handshake: a transfer happens on an edge where valid && ready. The whole pipe
  // advances only when the output slot is empty or being consumed, so in_ready = adv.
  assign adv          = !out_valid || out_ready;
  assign in_ready     = adv;
  assign out_valid    = valid_q[PIPE_STAGES-1];
  assign shift_result = data_q[PIPE_STAGES-1];
  assign out_tag      = ctl_q[PIPE_STAGES-1].tag;
  assign unused_b     = ^operand_b[XLEN-1:SHW];

  // Unlisted sel codes decode to a plain left shift.
  always_comb begin
    req_ctl.right = (sel == 3'b001) || (sel == 3'b011) || (sel == 3'b101);
    req_ctl.rot   = (sel == 3'b100) || (sel == 3'b101);
    req_ctl.fill  = (sel == 3'b011) && operand_a[XLEN-1];
    req_ctl.shamt = operand_b[SHW-1:0];
    req_ctl.tag   = in_tag;
  end

  always_comb begin
    data_in[0] = operand_a;
    ctl_in[0]  = req_ctl;
    valid_d[0] = in_valid;
    for (int s = 1; s < PIPE_STAGES; s++) begin
      data_in[s] = data_q[s-1];
      ctl_in[s]  = ctl_q[s-1];
      valid_d[s] = valid_q[s-1];
    end
  end

  // Level k (shift by 2^k) belongs to stage floor(k*PIPE_STAGES/SHW).
  always_comb begin
    for (int s = 0; s < PIPE_STAGES; s++) begin
      data_d[s] = data_in[s];
      for (int k = 0; k < SHW; k++) begin
        if (((k * PIPE_STAGES) / SHW == s) && ctl_in[s].shamt[k])
          data_d[s] = level_shift(data_d[s], 1 << k, ctl_in[s].right,
                                  ctl_in[s].rot, ctl_in[s].fill);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        data_q[s] <= '0;
        ctl_q[s]  <= '0;
      end
    end else begin
      if (flush)
        valid_q <= '0;
      else if (adv)
        valid_q <= valid_d;
      if (adv) begin
        for (int s = 0; s < PIPE_STAGES; s++) begin
          data_q[s] <= data_d[s];
          ctl_q[s]  <= ctl_in[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: 32-bit/2-stage instance with directed, backpressure, flush,
// reset and random traffic, plus 64-bit instances at 1, 3 and 6 stages.
module tb_shift_pipe;
  localparam int P32 = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // 32-bit instance
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] opa, opb, res;
  logic [2:0]  sel;
  logic [4:0]  tag_i, tag_o;

  shift_pipe #(.XLEN(32), .PIPE_STAGES(P32), .TAG_W(5)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(opa), .operand_b(opb), .sel(sel), .in_tag(tag_i),
    .out_valid(out_valid), .out_ready(out_ready), .shift_result(res), .out_tag(tag_o)
  );

  // 64-bit instances, always ready, never flushed
  logic        lo = 1'b0;
  logic        hi = 1'b1;
  logic        v64;
  logic [63:0] a64, b64;
  logic [2:0]  s64;
  logic [4:0]  t64;
  logic        ir64 [3];
  logic        ov64 [3];
  logic [63:0] r64  [3];
  logic [4:0]  to64 [3];
  int          p64  [3] = '{1, 3, 6};

  shift_pipe #(.XLEN(64), .PIPE_STAGES(1), .TAG_W(5)) u_p1 (
    .clk(clk), .rst(rst), .flush(lo), .in_valid(v64), .in_ready(ir64[0]),
    .operand_a(a64), .operand_b(b64), .sel(s64), .in_tag(t64),
    .out_valid(ov64[0]), .out_ready(hi), .shift_result(r64[0]), .out_tag(to64[0])
  );
  shift_pipe #(.XLEN(64), .PIPE_STAGES(3), .TAG_W(5)) u_p3 (
    .clk(clk), .rst(rst), .flush(lo), .in_valid(v64), .in_ready(ir64[1]),
    .operand_a(a64), .operand_b(b64), .sel(s64), .in_tag(t64),
    .out_valid(ov64[1]), .out_ready(hi), .shift_result(r64[1]), .out_tag(to64[1])
  );
  shift_pipe #(.XLEN(64), .PIPE_STAGES(6), .TAG_W(5)) u_p6 (
    .clk(clk), .rst(rst), .flush(lo), .in_valid(v64), .in_ready(ir64[2]),
    .operand_a(a64), .operand_b(b64), .sel(s64), .in_tag(t64),
    .out_valid(ov64[2]), .out_ready(hi), .shift_result(r64[2]), .out_tag(to64[2])
  );

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: straight from the operation definitions on an xlen-bit value.
  function automatic logic [63:0] ref_shift(input logic [63:0] a_in, input logic [63:0] b,
                                            input logic [2:0] s, input int xlen);
    logic [63:0] mask, a, r;
    int sh;
    mask = (xlen == 64) ? '1 : ((64'd1 << xlen) - 64'd1);
    a    = a_in & mask;
    sh   = int'(b & 64'(xlen - 1));
    case (s)
      3'b001: r = a >> sh;
      3'b011: begin
        r = a >> sh;
        if (a[xlen-1]) r = r | (mask & ~(mask >> sh));
      end
      3'b100: r = (sh == 0) ? a : ((a << sh) | (a >> (xlen - sh)));
      3'b101: r = (sh == 0) ? a : ((a >> sh) | (a << (xlen - sh)));
      default: r = a << sh;
    endcase
    return r & mask;
  endfunction

  // scoreboard for the 32-bit instance: {tag, result}
  logic [36:0] exp_q[$];
  logic        held_v = 1'b0;
  logic [31:0] held_r;
  logic [4:0]  held_t;
  logic        last_acc;

  task automatic step32(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] s, input logic [4:0] t,
                        input logic ordy, input logic fl);
    logic        acc, fire;
    logic [36:0] e;
    logic [63:0] m;
    @(negedge clk);
    in_valid = v; opa = a; opb = b; sel = s; tag_i = t; out_ready = ordy; flush = fl;
    #1;
    check_eq("in_ready", 64'(in_ready), 64'(!out_valid || ordy));
    if (held_v) begin
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_result", 64'(res), 64'(held_r));
      check_eq("hold_tag", 64'(tag_o), 64'(held_t));
    end
    acc  = v && in_ready;
    fire = out_valid && ordy;
    if (out_valid && exp_q.size() == 0) begin
      check_eq("spurious_out", 64'(out_valid), 64'd0);
    end else if (fire) begin
      e = exp_q.pop_front();
      check_eq("result", 64'(res), 64'(e[31:0]));
      check_eq("tag", 64'(tag_o), 64'(e[36:32]));
    end
    held_v = out_valid && !ordy && !fl;
    held_r = res;
    held_t = tag_o;
    if (fl) begin
      exp_q.delete();
    end else if (acc) begin
      m = ref_shift(64'(a), 64'(b), s, 32);
      exp_q.push_back({t, m[31:0]});
    end
    last_acc = acc && !fl;
  endtask

  task automatic idle32();
    step32(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic drain32();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      idle32();
      n++;
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                         input logic [4:0] t, input logic [31:0] expv);
    int waits = 0;
    step32(1'b1, a, b, s, t, 1'b1, 1'b0);
    check_eq("accept", 64'(last_acc), 64'd1);
    idle32();
    while (!out_valid && waits < 10) begin
      idle32();
      waits++;
    end
    check_eq("latency", 64'(waits), 64'(P32 - 1));
    check_eq("dir_result", 64'(res), 64'(expv));
    check_eq("dir_tag", 64'(tag_o), 64'(t));
  endtask

  // history for the 64-bit sweep; each instance reads it at its own pace
  logic [63:0] h_a [512];
  logic [63:0] h_b [512];
  logic [2:0]  h_s [512];
  logic [4:0]  h_t [512];
  int          h_e [512];
  int          wr = 0;
  int          rd [3] = '{0, 0, 0};

  task automatic step64(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] s, input logic [4:0] t);
    logic [63:0] m;
    @(negedge clk);
    v64 = v; a64 = a; b64 = b; s64 = s; t64 = t;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("sw%0d_in_ready", p64[i]), 64'(ir64[i]), 64'd1);
      if (ov64[i]) begin
        if (rd[i] >= wr) begin
          check_eq($sformatf("sw%0d_spurious", p64[i]), 64'(ov64[i]), 64'd0);
        end else begin
          m = ref_shift(h_a[rd[i]], h_b[rd[i]], h_s[rd[i]], 64);
          check_eq($sformatf("sw%0d_result", p64[i]), r64[i], m);
          check_eq($sformatf("sw%0d_tag", p64[i]), 64'(to64[i]), 64'(h_t[rd[i]]));
          check_eq($sformatf("sw%0d_latency", p64[i]), 64'(edge_cnt - h_e[rd[i]]),
                   64'(p64[i] - 1));
          if (rd[i] == 0) check_eq($sformatf("sw%0d_sra63", p64[i]), r64[i], '1);
          rd[i]++;
        end
      end
    end
    if (v && wr < 512) begin
      h_a[wr] = a; h_b[wr] = b; h_s[wr] = s; h_t[wr] = t; h_e[wr] = edge_cnt + 1;
      wr++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int idx, cyc;
    flush = 0; in_valid = 0; out_ready = 1; opa = 0; opb = 0; sel = 0; tag_i = 0;
    v64 = 0; a64 = 0; b64 = 0; s64 = 0; t64 = 0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result", 64'(res), 64'd0);
    check_eq("rst_tag", 64'(tag_o), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) check_eq("rst_sw_valid", 64'(ov64[i]), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // directed single operations
    run_one(32'h8000_0010, 32'd4, 3'b011, 5'd7, 32'hF800_0001);
    run_one(32'h8000_0010, 32'd4, 3'b001, 5'd8, 32'h0800_0001);
    run_one(32'h8000_0001, 32'd1, 3'b100, 5'd9, 32'h0000_0003);
    run_one(32'h0000_0001, 32'h21, 3'b101, 5'd10, 32'h8000_0000);
    run_one(32'h1234_5678, 32'd0, 3'b100, 5'd11, 32'h1234_5678);
    run_one(32'h0000_0001, 32'd3, 3'b110, 5'd12, 32'h0000_0008);

    // tags 1..6 with out_ready held low for three cycles mid-stream
    idx = 0; cyc = 0;
    while (idx < 6 && cyc < 40) begin
      step32(1'b1, 32'h100 * (idx + 1), 32'(idx), 3'b000, 5'(idx + 1),
             !(cyc >= 3 && cyc < 6), 1'b0);
      if (last_acc) idx++;
      cyc++;
    end
    check_eq("bp_accepted", 64'(idx), 64'd6);
    drain32();

    // flush with two operations in flight
    step32(1'b1, 32'hF0, 32'd4, 3'b000, 5'd20, 1'b0, 1'b0);
    step32(1'b1, 32'h0F, 32'd8, 3'b000, 5'd21, 1'b0, 1'b0);
    step32(1'b1, 32'h55, 32'd1, 3'b000, 5'd22, 1'b0, 1'b1);
    check_eq("flush_pre_valid", 64'(out_valid), 64'd1);
    idle32();
    check_eq("flush_post_valid", 64'(out_valid), 64'd0);
    repeat (4) idle32();
    run_one(32'h3, 32'd2, 3'b000, 5'd23, 32'hC);

    // random traffic with backpressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      step32($urandom_range(0, 99) < 75, $urandom, $urandom, 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 31)), $urandom_range(0, 99) < 70,
             $urandom_range(0, 99) < 4);
    end
    drain32();

    // asynchronous reset mid-stream
    for (int i = 0; i < 4; i++)
      step32(1'b1, 32'h0001_0001 << i, 32'(i + 1), 3'b000, 5'(i + 1), 1'b1, 1'b0);
    check_eq("rst_mid_pre_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_valid", 64'(out_valid), 64'd0);
    check_eq("rst_mid_result", 64'(res), 64'd0);
    check_eq("rst_mid_tag", 64'(tag_o), 64'd0);
    exp_q.delete();
    held_v = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_rel_in_ready", 64'(in_ready), 64'd1);
    run_one(32'h1, 32'd31, 3'b000, 5'd3, 32'h8000_0000);
    repeat (3) idle32();
    check_eq("final_empty", 64'(exp_q.size()), 64'd0);

    // 64-bit sweep over stage counts
    step64(1'b1, 64'h8000_0000_0000_0000, 64'd63, 3'b011, 5'd1);
    step64(1'b1, 64'hDEAD_BEEF_0123_4567, 64'd0, 3'b100, 5'd2);
    step64(1'b1, 64'hDEAD_BEEF_0123_4567, 64'd63, 3'b101, 5'd3);
    step64(1'b1, 64'h1, 64'hFFFF_FFFF_FFFF_FFC1, 3'b000, 5'd4);
    for (int i = 0; i < 250; i++) begin
      step64($urandom_range(0, 99) < 80, {$urandom, $urandom}, {$urandom, $urandom},
             3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end
    repeat (10) step64(1'b0, 64'd0, 64'd0, 3'd0, 5'd0);
    for (int i = 0; i < 3; i++) check_eq($sformatf("sw%0d_drain", p64[i]), 64'(rd[i]), 64'(wr));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
